// File: rtl/sd_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : sd_req_arbiter_if
// Brief   : Channel request and SD-controller handshake bundle for sd_req_arbiter
// Revision: 1.0 - initial release
// ============================================================================
interface sd_req_arbiter_if;
    logic [3:0]  enable;
    logic [3:0]  rd_req;
    logic [3:0]  wr_req;
    logic [31:0] lba [4];
    logic [3:0]  req_busy;
    logic [3:0]  req_done;
    logic [3:0]  req_err;
    logic [3:0]  sd_rd;
    logic [3:0]  sd_wr;
    logic [31:0] sd_lba;
    logic        sd_busy;
    logic        sd_done;
    logic [1:0]  grant;
    logic        active;

    modport master (
        output enable, rd_req, wr_req, lba, sd_busy, sd_done,
        input  req_busy, req_done, req_err, sd_rd, sd_wr, sd_lba, grant, active
    );

    modport slave (
        input  enable, rd_req, wr_req, lba, sd_busy, sd_done,
        output req_busy, req_done, req_err, sd_rd, sd_wr, sd_lba, grant, active
    );
endinterface
`default_nettype wire

// File: rtl/sd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sd_req_arbiter
// Brief   : Round-robin arbiter of four sector-request channels onto one SD
//           controller, with per-phase watchdog timeout
// Revision: 1.0 - initial release
// ============================================================================
module sd_req_arbiter #(
    parameter int TIMEOUT = 65535
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    sd_req_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam logic [15:0] c_timer_last = 16'(TIMEOUT - 1);

    state_t      r_state,    w_state_nx;
    logic [1:0]  r_last,     w_last_nx;
    logic [1:0]  r_ch,       w_ch_nx;
    logic [15:0] r_timer,    w_timer_nx;
    logic [3:0]  r_sd_rd,    w_sd_rd_nx;
    logic [3:0]  r_sd_wr,    w_sd_wr_nx;
    logic [31:0] r_sd_lba,   w_sd_lba_nx;
    logic [3:0]  r_req_busy, w_req_busy_nx;
    logic [3:0]  r_req_done, w_req_done_nx;
    logic [3:0]  r_req_err,  w_req_err_nx;
    logic [1:0]  r_grant,    w_grant_nx;
    logic        r_active,   w_active_nx;

    logic [3:0]  w_pending;
    logic [3:0]  w_ch_oh;
    logic [1:0]  w_idx;
    logic [1:0]  w_sel;
    logic        w_found;

    assign w_pending = (bus.rd_req | bus.wr_req) & bus.enable;
    assign w_ch_oh   = 4'b0001 << r_ch;

    // Rotating priority: first pending channel after the last one served
    always_comb begin
        w_idx   = 2'd0;
        w_sel   = 2'd0;
        w_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && w_pending[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_last_nx     = r_last;
        w_ch_nx       = r_ch;
        w_timer_nx    = r_timer;
        w_sd_rd_nx    = r_sd_rd;
        w_sd_wr_nx    = r_sd_wr;
        w_sd_lba_nx   = r_sd_lba;
        w_req_busy_nx = 4'b0000;
        w_req_done_nx = 4'b0000;
        w_req_err_nx  = 4'b0000;
        w_grant_nx    = r_grant;

        case (r_state)
            ST_IDLE: begin
                w_timer_nx = 16'd0;
                if (w_found) begin
                    w_state_nx  = ST_REQ;
                    w_ch_nx     = w_sel;
                    w_grant_nx  = w_sel;
                    w_sd_lba_nx = bus.lba[w_sel];
                    // Read wins when both are requested; the write stays pending
                    if (bus.rd_req[w_sel]) begin
                        w_sd_rd_nx = 4'b0001 << w_sel;
                    end else begin
                        w_sd_wr_nx = 4'b0001 << w_sel;
                    end
                end
            end

            ST_REQ: begin
                w_timer_nx = r_timer + 16'd1;
                if (bus.sd_busy) begin
                    w_sd_rd_nx    = 4'b0000;
                    w_sd_wr_nx    = 4'b0000;
                    w_req_busy_nx = w_ch_oh;
                    w_timer_nx    = 16'd0;
                    if (bus.sd_done) begin
                        w_req_done_nx = w_ch_oh;
                        w_last_nx     = r_ch;
                        w_state_nx    = ST_IDLE;
                    end else begin
                        w_state_nx    = ST_XFER;
                    end
                end else if (r_timer == c_timer_last) begin
                    w_sd_rd_nx   = 4'b0000;
                    w_sd_wr_nx   = 4'b0000;
                    w_req_err_nx = w_ch_oh;
                    w_last_nx    = r_ch;
                    w_state_nx   = ST_IDLE;
                end
            end

            ST_XFER: begin
                w_timer_nx = r_timer + 16'd1;
                if (bus.sd_done) begin
                    w_req_done_nx = w_ch_oh;
                    w_last_nx     = r_ch;
                    w_state_nx    = ST_IDLE;
                end else if (r_timer == c_timer_last) begin
                    w_req_err_nx = w_ch_oh;
                    w_last_nx    = r_ch;
                    w_state_nx   = ST_IDLE;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
                w_sd_rd_nx = 4'b0000;
                w_sd_wr_nx = 4'b0000;
            end
        endcase

        w_active_nx = (w_state_nx != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_last     <= 2'd3;
            r_ch       <= 2'd0;
            r_timer    <= 16'd0;
            r_sd_rd    <= 4'b0000;
            r_sd_wr    <= 4'b0000;
            r_sd_lba   <= 32'd0;
            r_req_busy <= 4'b0000;
            r_req_done <= 4'b0000;
            r_req_err  <= 4'b0000;
            r_grant    <= 2'd0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_last     <= w_last_nx;
            r_ch       <= w_ch_nx;
            r_timer    <= w_timer_nx;
            r_sd_rd    <= w_sd_rd_nx;
            r_sd_wr    <= w_sd_wr_nx;
            r_sd_lba   <= w_sd_lba_nx;
            r_req_busy <= w_req_busy_nx;
            r_req_done <= w_req_done_nx;
            r_req_err  <= w_req_err_nx;
            r_grant    <= w_grant_nx;
            r_active   <= w_active_nx;
        end
    end

    assign bus.sd_rd    = r_sd_rd;
    assign bus.sd_wr    = r_sd_wr;
    assign bus.sd_lba   = r_sd_lba;
    assign bus.req_busy = r_req_busy;
    assign bus.req_done = r_req_done;
    assign bus.req_err  = r_req_err;
    assign bus.grant    = r_grant;
    assign bus.active   = r_active;

endmodule
`default_nettype wire

// File: tb/tb_sd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_req_arbiter
// Brief   : Directed vector table plus hand sequences for sd_req_arbiter
// Revision: 1.0 - initial release
// ============================================================================
module tb_sd_req_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    sd_req_arbiter_if bus ();

    sd_req_arbiter #(.TIMEOUT(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [31:0] base;
        logic        granted;
        logic [3:0]  exp_rd;
        logic [3:0]  exp_wr;
        logic [1:0]  exp_grant;
        logic [31:0] exp_lba;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_lba(input logic [31:0] base);
        for (int i = 0; i < 4; i++) bus.lba[i] = base + 32'(i * 16);
    endtask

    // Waits (bounded) for a strobe; returns at the negedge it is first seen
    task automatic wait_strobe(input string name, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((bus.sd_rd | bus.sd_wr) != 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s no strobe within 20 cycles", name);
        end
    endtask

    // Called at the negedge where the strobe is visible; busy then done
    task automatic complete(input string name, input logic [3:0] oh,
                            input logic [3:0] new_rd, input logic [3:0] new_wr);
        @(negedge clk);
        bus.sd_busy = 1'b1;
        bus.rd_req  = new_rd;
        bus.wr_req  = new_wr;
        @(negedge clk);
        bus.sd_busy = 1'b0;
        chk({name, ".req_busy"}, 32'(bus.req_busy), 32'(oh));
        chk({name, ".strobe_off"}, 32'(bus.sd_rd | bus.sd_wr), 32'h0);
        @(negedge clk);
        bus.sd_done = 1'b1;
        @(negedge clk);
        bus.sd_done = 1'b0;
        chk({name, ".req_done"}, 32'(bus.req_done), 32'(oh));
        chk({name, ".idle"}, 32'(bus.active), 32'h0);
    endtask

    initial begin
        logic ok;
        logic [3:0] exp_rr [5];

        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.enable  = 4'b0000;
        bus.rd_req  = 4'b0000;
        bus.wr_req  = 4'b0000;
        bus.sd_busy = 1'b0;
        bus.sd_done = 1'b0;
        set_lba(32'h0);

        vecs[0] = '{4'b1111, 4'b0001, 4'b0000, 32'h0000_0100, 1'b1, 4'b0001, 4'b0000, 2'd0, 32'h0000_0100};
        vecs[1] = '{4'b1111, 4'b0000, 4'b0100, 32'h0000_2000, 1'b1, 4'b0000, 4'b0100, 2'd2, 32'h0000_2020};
        vecs[2] = '{4'b1111, 4'b1001, 4'b0000, 32'h0000_3000, 1'b1, 4'b1000, 4'b0000, 2'd3, 32'h0000_3030};
        vecs[3] = '{4'b1111, 4'b0011, 4'b0000, 32'h0000_4000, 1'b1, 4'b0001, 4'b0000, 2'd0, 32'h0000_4000};
        vecs[4] = '{4'b1111, 4'b0011, 4'b0000, 32'h0000_5000, 1'b1, 4'b0010, 4'b0000, 2'd1, 32'h0000_5010};
        vecs[5] = '{4'b1101, 4'b0000, 4'b0010, 32'h0000_6000, 1'b0, 4'b0000, 4'b0000, 2'd0, 32'h0000_0000};
        vecs[6] = '{4'b1101, 4'b0000, 4'b0001, 32'h0000_7000, 1'b1, 4'b0000, 4'b0001, 2'd0, 32'h0000_7000};
        vecs[7] = '{4'b1111, 4'b0100, 4'b0100, 32'h0000_8000, 1'b1, 4'b0100, 4'b0000, 2'd2, 32'h0000_8020};
        vecs[8] = '{4'b0111, 4'b1000, 4'b0001, 32'h0000_9000, 1'b1, 4'b0000, 4'b0001, 2'd0, 32'h0000_9000};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.active", 32'(bus.active), 32'h0);
        chk("rst.strobes", 32'(bus.sd_rd | bus.sd_wr), 32'h0);
        chk("rst.pulses", 32'(bus.req_busy | bus.req_done | bus.req_err), 32'h0);
        chk("rst.grant", 32'(bus.grant), 32'h0);
        chk("rst.sd_lba", bus.sd_lba, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Round robin with all channels held: 0,1,2,3,0
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
        bus.enable = 4'b1111;
        bus.rd_req = 4'b1111;
        set_lba(32'h0000_00A0);
        for (int k = 0; k < 5; k++) begin
            wait_strobe($sformatf("rr%0d", k), ok);
            if (ok) begin
                chk($sformatf("rr%0d.sd_rd", k), 32'(bus.sd_rd), 32'(exp_rr[k]));
                complete($sformatf("rr%0d", k), exp_rr[k], (k == 4) ? 4'b0000 : 4'b1111, 4'b0000);
            end
        end

        // Table: single transactions, one-cycle strobe latency
        for (int v = 0; v < 9; v++) begin
            bus.enable = vecs[v].en;
            bus.rd_req = vecs[v].rd;
            bus.wr_req = vecs[v].wr;
            set_lba(vecs[v].base);
            @(negedge clk);
            chk($sformatf("v%0d.sd_rd", v), 32'(bus.sd_rd), 32'(vecs[v].exp_rd));
            chk($sformatf("v%0d.sd_wr", v), 32'(bus.sd_wr), 32'(vecs[v].exp_wr));
            chk($sformatf("v%0d.active", v), 32'(bus.active), 32'(vecs[v].granted));
            if (vecs[v].granted) begin
                chk($sformatf("v%0d.grant", v), 32'(bus.grant), 32'(vecs[v].exp_grant));
                chk($sformatf("v%0d.sd_lba", v), bus.sd_lba, vecs[v].exp_lba);
                complete($sformatf("v%0d", v), vecs[v].exp_rd | vecs[v].exp_wr, 4'b0000, 4'b0000);
            end else begin
                repeat (3) @(negedge clk);
                chk($sformatf("v%0d.no_strobe", v), 32'(bus.sd_rd | bus.sd_wr), 32'h0);
                bus.rd_req = 4'b0000;
                bus.wr_req = 4'b0000;
            end
        end

        // Read and write on channel 2: read first, write afterwards
        bus.enable = 4'b1111;
        bus.rd_req = 4'b0100;
        bus.wr_req = 4'b0100;
        wait_strobe("rw.first", ok);
        if (ok) begin
            chk("rw.first.sd_rd", 32'(bus.sd_rd), 32'h4);
            complete("rw.first", 4'b0100, 4'b0000, 4'b0100);
        end
        wait_strobe("rw.second", ok);
        if (ok) begin
            chk("rw.second.sd_wr", 32'(bus.sd_wr), 32'h4);
            complete("rw.second", 4'b0100, 4'b0000, 4'b0000);
        end

        // sd_busy in IDLE is ignored
        bus.sd_busy = 1'b1;
        @(negedge clk);
        bus.sd_busy = 1'b0;
        chk("idle_busy.req_busy", 32'(bus.req_busy), 32'h0);
        chk("idle_busy.active", 32'(bus.active), 32'h0);

        // Watchdog in REQ (TIMEOUT=16), with a stray sd_done ignored
        bus.rd_req = 4'b0010;
        @(negedge clk);
        chk("tmo.sd_rd", 32'(bus.sd_rd), 32'h2);
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            bus.sd_done = (i == 4);
            if (i == 5) begin
                chk("tmo.stray_done", 32'(bus.req_done), 32'h0);
                chk("tmo.still_active", 32'(bus.active), 32'h1);
            end
        end
        chk("tmo.held_strobe", 32'(bus.sd_rd), 32'h2);
        chk("tmo.no_early_err", 32'(bus.req_err), 32'h0);
        @(negedge clk);
        chk("tmo.req_err", 32'(bus.req_err), 32'h2);
        chk("tmo.strobe_off", 32'(bus.sd_rd), 32'h0);
        chk("tmo.active", 32'(bus.active), 32'h0);
        bus.rd_req = 4'b0000;
        @(negedge clk);
        chk("tmo.err_pulse", 32'(bus.req_err), 32'h0);

        // Reset during XFER; priority pointer returns to channel 0
        bus.rd_req = 4'b1001;
        set_lba(32'h0000_C000);
        wait_strobe("rstx.first", ok);
        if (ok) chk("rstx.first.sd_rd", 32'(bus.sd_rd), 32'h8);
        @(negedge clk);
        bus.sd_busy = 1'b1;
        @(negedge clk);
        bus.sd_busy = 1'b0;
        chk("rstx.in_xfer", 32'(bus.req_busy), 32'h8);
        #2 reset_n = 1'b0;
        #1;
        chk("rstx.async_active", 32'(bus.active), 32'h0);
        chk("rstx.async_busy", 32'(bus.req_busy), 32'h0);
        chk("rstx.async_grant", 32'(bus.grant), 32'h0);
        @(negedge clk);
        chk("rstx.no_done", 32'(bus.req_done | bus.req_err), 32'h0);
        reset_n = 1'b1;
        wait_strobe("rstx.regrant", ok);
        if (ok) begin
            chk("rstx.regrant.sd_rd", 32'(bus.sd_rd), 32'h1);
            chk("rstx.regrant.sd_lba", bus.sd_lba, 32'h0000_C000);
            complete("rstx", 4'b0001, 4'b0000, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // One-hot strobe invariant, checked on every falling edge out of reset
    always @(negedge clk) begin
        if (reset_n && !$onehot0(bus.sd_rd | bus.sd_wr)) begin
            checks++;
            failures++;
            $display("FAIL onehot actual=%b required=onehot0", bus.sd_rd | bus.sd_wr);
        end
    end

endmodule
`default_nettype wire
